// File: rtl/sc_mul_8_top.sv
// Fully unrolled stochastic-computing multiplier: ramp and bit-reversed unipolar
// streams are ANDed, popcounted and rescaled into a registered approximate product.
module sc_mul_8_top #(
    parameter int DATA_WIDTH    = 8,
    parameter int STREAM_LENGTH = 16,
    parameter int ValidBitwth   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     io_inputs_a,
    input  logic [DATA_WIDTH-1:0]     io_inputs_b,
    output logic [2*DATA_WIDTH-1:0]   mul_result
);

    localparam int LW   = $clog2(STREAM_LENGTH);
    localparam int CW   = LW + 1;
    localparam int OW   = 2 * DATA_WIDTH;
    localparam int DROP = DATA_WIDTH - ValidBitwth;
    localparam int S    = ValidBitwth - LW;
    localparam int SH   = OW - LW;

    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [DATA_WIDTH-1:0] thr_a, thr_b;
    logic [LW-1:0]         idx, rev;
    logic [CW-1:0]         cnt;
    logic [OW-1:0]         prod;

    // Quantized operands kept at full width so thresholds compare without truncation.
    assign a_q = io_inputs_a >> DROP;
    assign b_q = io_inputs_b >> DROP;

    always_comb begin
        cnt   = '0;
        idx   = '0;
        rev   = '0;
        thr_a = '0;
        thr_b = '0;
        for (int unsigned i = 0; i < STREAM_LENGTH; i++) begin
            idx = LW'(i);
            for (int unsigned k = 0; k < LW; k++) begin
                rev[k] = idx[LW-1-k];
            end
            thr_a = DATA_WIDTH'(idx) << S;
            thr_b = DATA_WIDTH'(rev) << S;
            cnt   = cnt + CW'((a_q > thr_a) && (b_q > thr_b));
        end
    end

    // A full-length count would shift out of range, so it clamps to all ones.
    always_comb begin
        if (cnt == CW'(STREAM_LENGTH)) begin
            prod = '1;
        end else begin
            prod = OW'(cnt) << SH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_result <= '0;
        end else begin
            mul_result <= prod;
        end
    end

endmodule

// File: tb/tb_sc_mul_8_top.sv
// Self-checking bench for sc_mul_8_top: directed corner cases plus streaming and
// random operands, all compared against an arithmetic reference model.
module tb_sc_mul_8_top;

    logic        clk;
    logic        rst;
    logic [7:0]  io_inputs_a;
    logic [7:0]  io_inputs_b;
    logic [15:0] mul_result;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_val;
    logic        exp_valid = 1'b0;

    sc_mul_8_top #(
        .DATA_WIDTH(8),
        .STREAM_LENGTH(16),
        .ValidBitwth(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_inputs_a(io_inputs_a),
        .io_inputs_b(io_inputs_b),
        .mul_result(mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count stream positions where both operands exceed their thresholds.
    function automatic logic [15:0] model(input int a, input int b);
        int aq, bq, cnt, r, t;
        aq  = a / 8;
        bq  = b / 8;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            r = 0;
            t = i;
            for (int k = 0; k < 4; k++) begin
                r = r * 2 + (t % 2);
                t = t / 2;
            end
            if (aq > i * 2 && bq > r * 2) cnt++;
        end
        if (cnt == 16) return 16'hFFFF;
        return 16'(cnt * 4096);
    endfunction

    always @(posedge clk) begin
        exp_val   <= rst ? 16'h0000 : model(int'(io_inputs_a), int'(io_inputs_b));
        exp_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if ($isunknown(mul_result) || mul_result !== exp_val) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, mul_result, exp_val);
            end
            checks++;
            if (mul_result != 16'hFFFF && mul_result[11:0] != 12'h000) begin
                errors++;
                $display("FAIL grid t=%0t got=%h expected multiple of 0x1000 or FFFF", $time, mul_result);
            end
        end
    end

    task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic r);
        io_inputs_a = a;
        io_inputs_b = b;
        rst         = r;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [15:0] want);
        checks++;
        if (mul_result !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, mul_result, want);
        end
    endtask

    task automatic pin(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s model=%h expected=%h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] a, b;

        pin("model_128_128", model(128, 128), 16'h4000);
        pin("model_255_255", model(255, 255), 16'hFFFF);
        pin("model_0_255",   model(0, 255),   16'h0000);
        pin("model_200_200", model(200, 200), 16'hB000);

        io_inputs_a = 8'd200;
        io_inputs_b = 8'd200;
        rst         = 1'b1;

        cyc(8'd200, 8'd200, 1'b1); lit("reset_0", 16'h0000);
        cyc(8'd200, 8'd200, 1'b1); lit("reset_1", 16'h0000);
        cyc(8'd200, 8'd200, 1'b0); lit("first_200_200", 16'hB000);

        cyc(8'd0,   8'd255, 1'b0); lit("zero_a", 16'h0000);
        cyc(8'd255, 8'd255, 1'b0); lit("saturate", 16'hFFFF);
        cyc(8'd255, 8'd128, 1'b0); lit("full_half", 16'h8000);
        cyc(8'd128, 8'd128, 1'b0); lit("mid_scale", 16'h4000);
        cyc(8'd11,  8'd12,  1'b0); lit("small_11_12", 16'h1000);
        cyc(8'd14,  8'd15,  1'b0); lit("small_14_15", 16'h1000);

        // Inputs change mid-cycle; the registered output must hold.
        io_inputs_a = 8'd0;
        io_inputs_b = 8'd0;
        #1;
        lit("no_comb_path", 16'h1000);

        a = 8'd11;
        b = 8'd12;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                cyc(a, b, 1'b1);
                lit("mid_reset", 16'h0000);
            end else begin
                cyc(a, b, 1'b0);
            end
            a = a + 8'd3;
            b = b + 8'd3;
        end

        for (int n = 0; n < 2000; n++) begin
            cyc(8'($urandom), 8'($urandom), ($urandom_range(0, 63) == 0));
        end

        cyc(8'd255, 8'd255, 1'b0); lit("final_saturate", 16'hFFFF);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
